// File: rtl/axil_apb_bridge_pkg.sv
// Shared types and constants for the AXI-Lite to APB bridge and its address decoder.
package axil_apb_bridge_pkg;

  localparam int APB_AW     = 32;
  localparam int APB_DW     = 32;
  localparam int PSTRB_W    = APB_DW / 8;
  localparam int NUM_SLAVES = 3;
  localparam int IDX_W      = 8;

  typedef struct packed {
    logic [IDX_W-1:0]  idx;
    logic [APB_AW-1:0] start_addr;
    logic [APB_AW-1:0] end_addr;
  } rule_t;

  typedef rule_t addr_map_t [NUM_SLAVES];

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_ACCESS,
    ST_WRESP,
    ST_RRESP
  } state_t;

endpackage

// File: rtl/axil_apb_addr_decoder.sv
// Combinational address decoder: first rule with start <= addr < end selects the slave named by its idx.
module axil_apb_addr_decoder
  import axil_apb_bridge_pkg::*;
#(
  parameter int SLAVES_QTY = 3
) (
  input  logic [APB_AW-1:0]     addr,
  input  rule_t                 addr_map [SLAVES_QTY],
  output logic [SLAVES_QTY-1:0] sel,
  output logic                  match,
  output logic [IDX_W-1:0]      index
);

  always_comb begin
    match = 1'b0;
    index = '0;
    // Walk downward so the lowest-numbered matching rule is the one that sticks.
    for (int i = SLAVES_QTY - 1; i >= 0; i--) begin
      if (addr >= addr_map[i].start_addr && addr < addr_map[i].end_addr &&
          addr_map[i].idx < IDX_W'(SLAVES_QTY)) begin
        match = 1'b1;
        index = addr_map[i].idx;
      end
    end
    for (int j = 0; j < SLAVES_QTY; j++) begin
      sel[j] = match && (index == IDX_W'(j));
    end
  end

endmodule

// File: rtl/axil_apb_bridge.sv
// AXI4-Lite responder issuing one APB transfer at a time to a decoded slave, with round-robin
// arbitration between read and write, DECERR on unmapped addresses and an ACCESS-phase timeout.
module axil_apb_bridge
  import axil_apb_bridge_pkg::*;
#(
  parameter int SLAVES_QTY     = 3,
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic                  pclk,
  input  logic                  prst,
  input  rule_t                 addr_map [SLAVES_QTY],
  input  logic [APB_AW-1:0]     AWADDR,
  input  logic [2:0]            AWPROT,
  input  logic                  AWVALID,
  output logic                  AWREADY,
  input  logic [APB_DW-1:0]     WDATA,
  input  logic [PSTRB_W-1:0]    WSTRB,
  input  logic                  WVALID,
  output logic                  WREADY,
  output logic [1:0]            BRESP,
  output logic                  BVALID,
  input  logic                  BREADY,
  input  logic [APB_AW-1:0]     ARADDR,
  input  logic [2:0]            ARPROT,
  input  logic                  ARVALID,
  output logic                  ARREADY,
  output logic [APB_DW-1:0]     RDATA,
  output logic [1:0]            RRESP,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [APB_AW-1:0]     paddr,
  output logic [2:0]            pprot,
  output logic                  pwrite,
  output logic [APB_DW-1:0]     pwdata,
  output logic [PSTRB_W-1:0]    pstrb,
  output logic [SLAVES_QTY-1:0] psel,
  output logic                  penable,
  input  logic [APB_DW-1:0]     prdata [SLAVES_QTY],
  input  logic [SLAVES_QTY-1:0] pready,
  input  logic [SLAVES_QTY-1:0] pslverr
);

  localparam int TO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  state_t                  state, state_nxt;
  logic [SLAVES_QTY-1:0]   sel_q, dec_sel;
  logic [IDX_W-1:0]        idx_q, dec_index;
  logic                    dec_match;
  logic [APB_AW-1:0]       dec_addr;
  logic [1:0]              resp_q;
  logic [APB_DW-1:0]       rdata_q, prdata_sel;
  logic                    last_wr, grant_wr, grant_rd;
  logic                    pready_sel, pslverr_sel, timeout_hit;
  logic [TO_W-1:0]         to_cnt;

  // Write wins unless the previous grant was also a write and a read is waiting.
  assign grant_wr = (state == ST_IDLE) && AWVALID && WVALID && (!ARVALID || !last_wr);
  assign grant_rd = (state == ST_IDLE) && ARVALID && !grant_wr;
  assign dec_addr = grant_wr ? AWADDR : ARADDR;

  axil_apb_addr_decoder #(.SLAVES_QTY(SLAVES_QTY)) u_decoder (
    .addr     (dec_addr),
    .addr_map (addr_map),
    .sel      (dec_sel),
    .match    (dec_match),
    .index    (dec_index)
  );

  always_comb begin
    pready_sel  = 1'b0;
    pslverr_sel = 1'b0;
    prdata_sel  = '0;
    for (int i = 0; i < SLAVES_QTY; i++) begin
      if (idx_q == IDX_W'(i)) begin
        pready_sel  = pready[i];
        pslverr_sel = pslverr[i];
        prdata_sel  = prdata[i];
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYCLES != 0) && (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) state <= ST_IDLE;
    else      state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    AWREADY   = 1'b0;
    WREADY    = 1'b0;
    ARREADY   = 1'b0;
    case (state)
      ST_IDLE: begin
        if (grant_wr) begin
          AWREADY   = 1'b1;
          WREADY    = 1'b1;
          state_nxt = dec_match ? ST_SETUP : ST_WRESP;
        end else if (grant_rd) begin
          ARREADY   = 1'b1;
          state_nxt = dec_match ? ST_SETUP : ST_RRESP;
        end
      end
      ST_SETUP:  state_nxt = ST_ACCESS;
      ST_ACCESS: if (pready_sel || timeout_hit) state_nxt = pwrite ? ST_WRESP : ST_RRESP;
      ST_WRESP:  if (BREADY) state_nxt = ST_IDLE;
      ST_RRESP:  if (RREADY) state_nxt = ST_IDLE;
      default:   state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge pclk or posedge prst) begin
    if (prst) begin
      paddr   <= '0;
      pwdata  <= '0;
      pstrb   <= '0;
      pprot   <= '0;
      pwrite  <= 1'b0;
      sel_q   <= '0;
      idx_q   <= '0;
      resp_q  <= RESP_OKAY;
      rdata_q <= '0;
      last_wr <= 1'b0;
      to_cnt  <= '0;
    end else if (grant_wr || grant_rd) begin
      paddr   <= dec_addr;
      pprot   <= grant_wr ? AWPROT : ARPROT;
      pstrb   <= grant_wr ? WSTRB : '0;
      pwrite  <= grant_wr;
      if (grant_wr) pwdata <= WDATA;
      sel_q   <= dec_sel;
      idx_q   <= dec_index;
      resp_q  <= dec_match ? RESP_OKAY : RESP_DECERR;
      rdata_q <= '0;
      last_wr <= grant_wr;
      to_cnt  <= '0;
    end else if (state == ST_ACCESS) begin
      if (pready_sel) begin
        resp_q  <= pslverr_sel ? RESP_SLVERR : RESP_OKAY;
        rdata_q <= pwrite ? '0 : prdata_sel;
      end else if (timeout_hit) begin
        resp_q  <= RESP_SLVERR;
        rdata_q <= '0;
      end else begin
        to_cnt  <= to_cnt + TO_W'(1);
      end
    end
  end

  assign psel    = (state == ST_SETUP || state == ST_ACCESS) ? sel_q : '0;
  assign penable = (state == ST_ACCESS);
  assign BVALID  = (state == ST_WRESP);
  assign RVALID  = (state == ST_RRESP);
  assign BRESP   = resp_q;
  assign RRESP   = resp_q;
  assign RDATA   = rdata_q;

endmodule

// File: tb/tb_axil_apb_bridge.sv
// Self-checking bench for axil_apb_bridge: expected responses are queued at issue time and
// compared when BVALID/RVALID handshakes occur; timing and APB-side values are checked per transfer.
module tb_axil_apb_bridge;
  import axil_apb_bridge_pkg::*;

  logic        pclk, prst;
  rule_t       addr_map [3];
  logic [31:0] AWADDR, WDATA, ARADDR, RDATA, paddr, pwdata;
  logic [2:0]  AWPROT, ARPROT, pprot, psel, pready, pslverr;
  logic [3:0]  WSTRB, pstrb;
  logic        AWVALID, AWREADY, WVALID, WREADY, BVALID, BREADY;
  logic        ARVALID, ARREADY, RVALID, RREADY, pwrite, penable;
  logic [1:0]  BRESP, RRESP;
  logic [31:0] prdata [3];

  typedef struct {
    bit          wr;
    logic [1:0]  resp;
    logic [31:0] data;
  } exp_t;
  exp_t exp_q [$];

  int n_chk = 0;
  int n_fail = 0;

  logic [2:0]  psel_log   [64];
  logic        pen_log    [64];
  logic [3:0]  pstrb_log  [64];
  logic [31:0] pwdata_log [64];
  logic [31:0] paddr_log  [64];

  axil_apb_bridge #(.SLAVES_QTY(3), .TIMEOUT_CYCLES(16)) dut (
    .pclk(pclk), .prst(prst), .addr_map(addr_map),
    .AWADDR(AWADDR), .AWPROT(AWPROT), .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WVALID(WVALID), .WREADY(WREADY),
    .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARADDR(ARADDR), .ARPROT(ARPROT), .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RDATA(RDATA), .RRESP(RRESP), .RVALID(RVALID), .RREADY(RREADY),
    .paddr(paddr), .pprot(pprot), .pwrite(pwrite), .pwdata(pwdata), .pstrb(pstrb),
    .psel(psel), .penable(penable), .prdata(prdata), .pready(pready), .pslverr(pslverr)
  );

  initial begin
    pclk = 1'b0;
    forever #5 pclk = ~pclk;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge pclk);
    #1;
  endtask

  task automatic sb_pop(input bit wr, input logic [1:0] resp, input logic [31:0] data);
    exp_t e;
    if (exp_q.size() == 0) begin
      chk("sb_unexpected_resp", 32'd1, 32'd0);
      return;
    end
    e = exp_q.pop_front();
    chk("sb_dir", {31'd0, wr}, {31'd0, e.wr});
    chk("sb_resp", {30'd0, resp}, {30'd0, e.resp});
    if (!wr) chk("sb_rdata", data, e.data);
  endtask

  always @(negedge pclk) begin
    if (!prst && BVALID && BREADY) sb_pop(1'b1, BRESP, 32'h0);
    if (!prst && RVALID && RREADY) sb_pop(1'b0, RRESP, RDATA);
  end

  // Issue one transaction from an IDLE cycle; optionally present the other direction alongside
  // to observe arbitration. Returns after the response handshake, in an IDLE cycle.
  task automatic xfer(input string tag, input bit wr, input logic [31:0] addr,
                      input logic [31:0] data, input logic [3:0] strb, input logic [1:0] exp_resp,
                      input logic [31:0] exp_data, input int exp_lat, input bit other,
                      input bit early);
    int lat;
    exp_q.push_back('{wr: wr, resp: exp_resp, data: exp_data});
    if (wr) begin
      AWADDR = addr; AWPROT = 3'b010; WDATA = data; WSTRB = strb;
      AWVALID = 1'b1; WVALID = 1'b1;
      if (other) begin ARADDR = 32'h0000_0100; ARVALID = 1'b1; end
    end else begin
      ARADDR = addr; ARPROT = 3'b001; ARVALID = 1'b1;
      if (other) begin
        AWADDR = 32'h0000_0200; WDATA = 32'h0; WSTRB = 4'hF; AWVALID = 1'b1; WVALID = 1'b1;
      end
    end
    if (early) begin BREADY = 1'b1; RREADY = 1'b1; end
    #1;
    if (wr) begin
      chk({tag, "_awready"}, {31'd0, AWREADY && WREADY}, 32'd1);
      if (other) chk({tag, "_arready_blocked"}, {31'd0, ARREADY}, 32'd0);
    end else begin
      chk({tag, "_arready"}, {31'd0, ARREADY}, 32'd1);
      if (other) chk({tag, "_awready_blocked"}, {31'd0, AWREADY || WREADY}, 32'd0);
    end
    @(posedge pclk);
    #1;
    AWVALID = 1'b0; WVALID = 1'b0; ARVALID = 1'b0;
    lat = 1;
    while (lat < 63) begin
      psel_log[lat] = psel; pen_log[lat] = penable; pstrb_log[lat] = pstrb;
      pwdata_log[lat] = pwdata; paddr_log[lat] = paddr;
      if (wr ? BVALID : RVALID) break;
      tick();
      lat++;
    end
    chk({tag, "_latency"}, lat, exp_lat);
    if (!early) begin
      tick();
      chk({tag, "_valid_held"}, {31'd0, wr ? BVALID : RVALID}, 32'd1);
      if (!wr) chk({tag, "_rdata_held"}, RDATA, exp_data);
      BREADY = 1'b1; RREADY = 1'b1;
    end
    tick();
    chk({tag, "_valid_dropped"}, {31'd0, wr ? BVALID : RVALID}, 32'd0);
    BREADY = 1'b0; RREADY = 1'b0;
  endtask

  initial begin
    prst = 1'b1;
    addr_map[0] = '{idx: 8'd0, start_addr: 32'h0000_0000, end_addr: 32'h0000_1000};
    addr_map[1] = '{idx: 8'd1, start_addr: 32'h0000_1000, end_addr: 32'h0000_1040};
    addr_map[2] = '{idx: 8'd2, start_addr: 32'h0000_1040, end_addr: 32'h0000_1060};
    AWADDR = '0; AWPROT = '0; AWVALID = 1'b0; WDATA = '0; WSTRB = '0; WVALID = 1'b0;
    BREADY = 1'b0; ARADDR = '0; ARPROT = '0; ARVALID = 1'b0; RREADY = 1'b0;
    pready = 3'b111; pslverr = 3'b000;
    prdata[0] = 32'hDEAD_0000; prdata[1] = 32'h1234_5678; prdata[2] = 32'hCAFE_0002;
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_psel", {29'd0, psel}, 32'd0);
    chk("rst_penable", {31'd0, penable}, 32'd0);
    chk("rst_valids", {30'd0, BVALID, RVALID}, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_resp", {28'd0, BRESP, RRESP}, 32'd0);
    prst = 1'b0;
    tick();

    // Both directions pending after reset: write goes first.
    xfer("wr_slv2", 1'b1, 32'h0000_1048, 32'h0000_00A5, 4'hF, RESP_OKAY, 32'h0, 3, 1'b1, 1'b0);
    chk("wr_slv2_psel_setup", {29'd0, psel_log[1]}, 32'd4);
    chk("wr_slv2_pen_setup", {31'd0, pen_log[1]}, 32'd0);
    chk("wr_slv2_psel_access", {29'd0, psel_log[2]}, 32'd4);
    chk("wr_slv2_pen_access", {31'd0, pen_log[2]}, 32'd1);
    chk("wr_slv2_pwdata", pwdata_log[1], 32'h0000_00A5);
    chk("wr_slv2_paddr", paddr_log[1], 32'h0000_1048);
    chk("wr_slv2_pstrb", {28'd0, pstrb_log[1]}, 32'hF);

    // Both pending again: the read is now due.
    xfer("rr_read", 1'b0, 32'h0000_0100, 32'h0, 4'h0, RESP_OKAY, 32'hDEAD_0000, 3, 1'b1, 1'b0);

    // Slave1 read with 3 wait states; other slaves' pready/pslverr must be ignored.
    pready = 3'b101; pslverr = 3'b101;
    fork
      xfer("rd_wait", 1'b0, 32'h0000_1004, 32'h0, 4'h0, RESP_OKAY, 32'h1234_5678, 6, 1'b0, 1'b0);
      begin
        repeat (5) @(posedge pclk);
        #1;
        pready[1] = 1'b1;
      end
    join
    chk("rd_wait_psel", {29'd0, psel_log[1]}, 32'd2);
    chk("rd_wait_pstrb", {28'd0, pstrb_log[1]}, 32'd0);
    chk("rd_wait_pen_last", {31'd0, pen_log[5]}, 32'd1);
    pready = 3'b111; pslverr = 3'b000;

    xfer("wr_decerr", 1'b1, 32'h0000_2000, 32'h55, 4'hF, RESP_DECERR, 32'h0, 1, 1'b0, 1'b0);
    chk("wr_decerr_psel", {29'd0, psel_log[1]}, 32'd0);
    xfer("rd_decerr", 1'b0, 32'h0000_2000, 32'h0, 4'h0, RESP_DECERR, 32'h0, 1, 1'b0, 1'b0);

    pslverr = 3'b001;
    xfer("rd_slverr", 1'b0, 32'h0000_0010, 32'h0, 4'h0, RESP_SLVERR, 32'hDEAD_0000, 3, 1'b0, 1'b0);
    pslverr = 3'b000;

    pready = 3'b000;
    xfer("rd_timeout", 1'b0, 32'h0000_0010, 32'h0, 4'h0, RESP_SLVERR, 32'h0, 18, 1'b0, 1'b0);
    chk("rd_timeout_pen_last", {31'd0, pen_log[17]}, 32'd1);
    chk("rd_timeout_psel_last", {29'd0, psel_log[17]}, 32'd1);
    chk("rd_timeout_psel_drop", {29'd0, psel_log[18]}, 32'd0);
    pready = 3'b111;

    // AWVALID alone must never be accepted.
    AWADDR = 32'h0000_0040; AWVALID = 1'b1; WVALID = 1'b0;
    for (int i = 0; i < 4; i++) begin
      chk("lone_aw_ready", {31'd0, AWREADY || WREADY}, 32'd0);
      chk("lone_aw_psel", {29'd0, psel}, 32'd0);
      tick();
    end
    AWVALID = 1'b0;
    tick();

    // Ready already high when VALID rises: single-cycle response.
    xfer("wr_early", 1'b1, 32'h0000_1010, 32'h0BAD_F00D, 4'h3, RESP_OKAY, 32'h0, 3, 1'b0, 1'b1);
    xfer("rd_early", 1'b0, 32'h0000_1050, 32'h0, 4'h0, RESP_OKAY, 32'hCAFE_0002, 3, 1'b0, 1'b1);

    // Reset in the middle of ACCESS: transfer dropped without response.
    pready = 3'b000;
    ARADDR = 32'h0000_0010; ARVALID = 1'b1;
    tick();
    ARVALID = 1'b0;
    tick();
    chk("mid_rst_in_access", {31'd0, penable}, 32'd1);
    #2;
    prst = 1'b1;
    #1;
    chk("mid_rst_psel", {29'd0, psel}, 32'd0);
    chk("mid_rst_penable", {31'd0, penable}, 32'd0);
    chk("mid_rst_valids", {30'd0, BVALID, RVALID}, 32'd0);
    tick();
    prst = 1'b0;
    pready = 3'b111;
    RREADY = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("mid_rst_no_resp", {30'd0, BVALID, RVALID}, 32'd0);
      tick();
    end
    RREADY = 1'b0;
    xfer("wr_after_rst", 1'b1, 32'h0000_0300, 32'h7777_0001, 4'hF, RESP_OKAY, 32'h0, 3, 1'b0, 1'b0);

    tick();
    chk("sb_drained", exp_q.size(), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, expected finish before 200000");
    $fatal(1, "bench time limit reached");
  end

endmodule
